// File: rtl/seq_pattern_detector_if.sv
// Bit-stream and configuration bundle for seq_pattern_detector.
// master: the side feeding bits/config; slave: the detector itself.
interface seq_pattern_detector_if #(
    parameter int PAT_WIDTH = 4,
    parameter int CNT_WIDTH = 8
);
    logic                 bit_in;
    logic                 bit_valid;
    logic                 cfg_load;
    logic [PAT_WIDTH-1:0] cfg_pattern;
    logic [PAT_WIDTH-1:0] cfg_mask;
    logic                 cfg_overlap;
    logic                 count_clear;
    logic                 match_pulse;
    logic [CNT_WIDTH-1:0] pattern_count;
    logic                 count_overflow;

    modport master (
        output bit_in, bit_valid, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, count_clear,
        input  match_pulse, pattern_count, count_overflow
    );

    modport slave (
        input  bit_in, bit_valid, cfg_load, cfg_pattern, cfg_mask, cfg_overlap, count_clear,
        output match_pulse, pattern_count, count_overflow
    );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: programmable pattern and don't-care mask,
// overlapping / non-overlapping matching, saturating match counter with
// sticky overflow flag.
module seq_pattern_detector #(
    parameter int                   PAT_WIDTH     = 4,
    parameter int                   CNT_WIDTH     = 8,
    parameter logic [PAT_WIDTH-1:0] RESET_PATTERN = PAT_WIDTH'(4'b1011),
    parameter logic [PAT_WIDTH-1:0] RESET_MASK    = '1,
    parameter logic                 RESET_OVERLAP = 1'b0
) (
    input logic                   clock_100Mhz,
    input logic                   reset_n,
    seq_pattern_detector_if.slave bus
);
    localparam int FW = $clog2(PAT_WIDTH + 1);
    localparam logic [FW-1:0]        FILL_FULL = FW'(PAT_WIDTH);
    localparam logic [FW-1:0]        FILL_NEED = FW'(PAT_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

    // Only the newest PAT_WIDTH-1 bits are ever needed: the window is
    // completed by the bit arriving this cycle.
    logic [PAT_WIDTH-2:0] history;
    logic [FW-1:0]        fill;
    logic [PAT_WIDTH-1:0] pattern;
    logic [PAT_WIDTH-1:0] mask;
    logic                 overlap;
    logic [PAT_WIDTH-1:0] window;
    logic                 match;

    // Match decision on the window formed by stored history plus the incoming bit.
    always_comb begin
        window = {history, bus.bit_in};
        match  = 1'b0;
        if (bus.bit_valid && !bus.cfg_load && (fill >= FILL_NEED) &&
            (((window ^ pattern) & mask) == '0)) begin
            match = 1'b1;
        end
    end

    // Configuration, shift history, fill tracking and the match strobe.
    always_ff @(posedge clock_100Mhz) begin
        if (!reset_n) begin
            history         <= '0;
            fill            <= '0;
            pattern         <= RESET_PATTERN;
            mask            <= RESET_MASK;
            overlap         <= RESET_OVERLAP;
            bus.match_pulse <= 1'b0;
        end else begin
            bus.match_pulse <= match;
            if (bus.cfg_load) begin
                pattern <= bus.cfg_pattern;
                mask    <= bus.cfg_mask;
                overlap <= bus.cfg_overlap;
                history <= '0;
                fill    <= '0;
            end else if (bus.bit_valid) begin
                history <= window[PAT_WIDTH-2:0];
                if (match && !overlap) begin
                    fill <= '0;
                end else if (fill != FILL_FULL) begin
                    fill <= fill + 1'b1;
                end
            end
        end
    end

    // Saturating match counter; clear takes priority over a same-cycle match.
    always_ff @(posedge clock_100Mhz) begin
        if (!reset_n) begin
            bus.pattern_count  <= '0;
            bus.count_overflow <= 1'b0;
        end else if (bus.count_clear) begin
            bus.pattern_count  <= '0;
            bus.count_overflow <= 1'b0;
        end else if (match) begin
            if (bus.pattern_count == CNT_MAX) begin
                bus.count_overflow <= 1'b1;
            end else begin
                bus.pattern_count <= bus.pattern_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seq_pattern_detector.sv
// Scoreboard bench for seq_pattern_detector: two instances (8-bit and 2-bit
// counters) receive identical stimulus; a queue-based reference model
// predicts every cycle's outputs, and a monitor compares them.
module tb_seq_pattern_detector;
    localparam int PW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_pattern_detector_if #(.PAT_WIDTH(PW), .CNT_WIDTH(8)) if8 ();
    seq_pattern_detector_if #(.PAT_WIDTH(PW), .CNT_WIDTH(2)) if2 ();

    seq_pattern_detector #(.PAT_WIDTH(PW), .CNT_WIDTH(8)) dut8 (
        .clock_100Mhz(clk), .reset_n(rst_n), .bus(if8.slave));
    seq_pattern_detector #(.PAT_WIDTH(PW), .CNT_WIDTH(2)) dut2 (
        .clock_100Mhz(clk), .reset_n(rst_n), .bus(if2.slave));

    typedef struct {
        logic p;
        int   c8;
        logic o8;
        int   c2;
        logic o2;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model state: accepted bits since last restart, held as a list.
    int          mbits[$];
    logic [PW-1:0] mpat;
    logic [PW-1:0] mmask;
    logic        movl;
    int          mc8, mc2;
    logic        mo8, mo2;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare whatever the DUTs present against the oldest prediction.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            cmp("pulse8", 32'(if8.match_pulse), 32'(e.p));
            cmp("pulse2", 32'(if2.match_pulse), 32'(e.p));
            cmp("count8", 32'(if8.pattern_count), 32'(e.c8));
            cmp("ovf8", 32'(if8.count_overflow), 32'(e.o8));
            cmp("count2", 32'(if2.pattern_count), 32'(e.c2));
            cmp("ovf2", 32'(if2.count_overflow), 32'(e.o2));
        end
    end

    // Drive one cycle of inputs on both instances and record the model's prediction.
    task automatic cycle(input logic rn, input logic bv, input logic bi, input logic ld,
                         input logic [PW-1:0] pat, input logic [PW-1:0] msk,
                         input logic ov, input logic clr);
        logic m;
        int   n;
        exp_t e;
        @(negedge clk);
        rst_n = rn;
        if8.bit_valid = bv;   if2.bit_valid = bv;
        if8.bit_in = bi;      if2.bit_in = bi;
        if8.cfg_load = ld;    if2.cfg_load = ld;
        if8.cfg_pattern = pat; if2.cfg_pattern = pat;
        if8.cfg_mask = msk;   if2.cfg_mask = msk;
        if8.cfg_overlap = ov; if2.cfg_overlap = ov;
        if8.count_clear = clr; if2.count_clear = clr;
        m = 1'b0;
        if (!rn) begin
            mbits.delete();
            mpat = 4'b1011; mmask = 4'b1111; movl = 1'b0;
            mc8 = 0; mc2 = 0; mo8 = 1'b0; mo2 = 1'b0;
        end else begin
            if (ld) begin
                mpat = pat; mmask = msk; movl = ov;
                mbits.delete();
            end else if (bv) begin
                mbits.push_back(int'(bi));
                n = mbits.size();
                if (n >= PW) begin
                    m = 1'b1;
                    for (int i = 0; i < PW; i++) begin
                        if (mmask[PW-1-i] && (mbits[n-PW+i] != int'(mpat[PW-1-i]))) m = 1'b0;
                    end
                    if (m && !movl) mbits.delete();
                    else if (n > PW) void'(mbits.pop_front());
                end
            end
            if (clr) begin
                mc8 = 0; mc2 = 0; mo8 = 1'b0; mo2 = 1'b0;
            end else if (m) begin
                if (mc8 == 255) mo8 = 1'b1; else mc8++;
                if (mc2 == 3) mo2 = 1'b1; else mc2++;
            end
        end
        e.p = m; e.c8 = mc8; e.o8 = mo8; e.c2 = mc2; e.o2 = mo2;
        expq.push_back(e);
    endtask

    task automatic send(input logic b);
        cycle(1'b1, 1'b1, b, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic b);
        cycle(1'b1, 1'b0, b, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [PW-1:0] p, input logic [PW-1:0] m, input logic o);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, p, m, o, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w, input int len);
        for (int i = len - 1; i >= 0; i--) send(w[i]);
    endtask

    initial begin
        logic [31:0] s1011011;
        logic [31:0] tgl;
        logic [PW-1:0] rp, rm;
        s1011011 = 32'b1011011;
        tgl = 32'b0;

        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
        idle(1'b0);
        cmp("reset_count8", 32'(if8.pattern_count), 32'd0);
        cmp("reset_pulse8", 32'(if8.match_pulse), 32'd0);

        // Default config, non-overlap stream.
        send_word(s1011011, 7);
        idle(1'b0);
        cmp("t1_count8", 32'(if8.pattern_count), 32'd1);

        // Overlap mode on the same stream.
        load(4'b1011, 4'b1111, 1'b1);
        send_word(s1011011, 7);
        idle(1'b0);
        cmp("t2_count8", 32'(if8.pattern_count), 32'd3);
        cmp("t2_count2", 32'(if2.pattern_count), 32'd3);
        cmp("t2_ovf2", 32'(if2.count_overflow), 32'd0);

        // Mask all don't-care, overlap: saturate the 2-bit counter.
        load(4'b0000, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) send(1'($urandom_range(0, 1)));
        idle(1'b0);
        cmp("t4_count2", 32'(if2.pattern_count), 32'd3);
        cmp("t4_ovf2", 32'(if2.count_overflow), 32'd1);
        cmp("t4_count8", 32'(if8.pattern_count), 32'd5);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        idle(1'b0);
        cmp("t4_clr_pulse8", 32'(if8.match_pulse), 32'd1);
        cmp("t4_clr_count8", 32'(if8.pattern_count), 32'd0);
        cmp("t4_clr_ovf2", 32'(if2.count_overflow), 32'd0);

        // Idle gaps with toggling bit_in between accepted bits.
        load(4'b1011, 4'b1111, 1'b0);
        for (int i = 6; i >= 0; i--) begin
            send(s1011011[i]);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                tgl[0] = ~tgl[0];
                idle(tgl[0]);
            end
        end
        idle(1'b0);
        cmp("t3_count8", 32'(if8.pattern_count), 32'd1);

        // Partial mask.
        load(4'b1011, 4'b1001, 1'b0);
        send_word(32'b1001, 4);
        send_word(32'b1111, 4);
        send_word(32'b0011, 4);
        idle(1'b0);
        cmp("t5_count8", 32'(if8.pattern_count), 32'd3);

        // Reset mid-stream, then cfg_load with a same-cycle bit.
        send_word(32'b101, 3);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        send(1'b1);
        idle(1'b0);
        cmp("t6_count8", 32'(if8.pattern_count), 32'd0);
        cycle(1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b1111, 1'b0, 1'b0);
        send_word(32'b011, 3);
        idle(1'b0);
        cmp("t6_drop_pulse8", 32'(if8.match_pulse), 32'd0);
        cmp("t6_drop_count8", 32'(if8.pattern_count), 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0, '0, 1'b0, 1'b0);
            end else if ($urandom_range(0, 39) == 0) begin
                rp = PW'($urandom);
                rm = PW'($urandom) | PW'($urandom);
                cycle(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                      rp, rm, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 30) == 0));
            end else begin
                cycle(1'b1, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'b0,
                      PW'($urandom), PW'($urandom), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 49) == 0));
            end
        end

        @(posedge clk);
        #2;
        if (expq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d predictions left, expected 0", expq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
